// File: rtl/bcd_addsub_seq.sv
// bcd_addsub_seq: sequential add/subtract with decimal readout.
// The operands are latched on start. The result magnitude is then converted
// to packed BCD by a shift-add-3 (double-dabble) engine at one bit per clock.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// CONV  | shift-add-3 iterations 1..W over the latched magnitude
// DONE  | final iteration W+1 feeds the output registers; done pulses next
//
// Outputs are registered, so they lag the state by one edge. busy covers CONV
// and DONE. The done pulse appears in the cycle after DONE, and the FSM is
// already back in IDLE during that cycle. This gives W+1 cycles of latency and
// a W+2 cycle start-to-start period.
module bcd_addsub_seq #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [W:0]       sum,
  output logic             neg,
  output logic [4*D-1:0]   bcd
);

  localparam int CW = $clog2(W + 2);
  localparam int SW = 4 * D + W + 1;

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // D digits must hold the largest magnitude, 2^(W+1)-1
  if ((W < 2) || (pow10(D) <= ((64'd1 << (W + 1)) - 64'd1))) begin : g_bad_params
    $fatal(1, "bcd_addsub_seq: illegal parameters W=%0d D=%0d", W, D);
  end

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   sr;
  logic [W:0]      r_q;
  logic            neg_q;

  logic [W:0]      r;
  logic [W:0]      mag;
  logic            neg_c;
  logic [SW-1:0]   adj;
  logic [SW-1:0]   nxt;

  // raw (W+1)-bit result, sign and magnitude of the live operands
  always_comb begin
    r = '0;
    if (sub)
      r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
    else
      r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    neg_c = sub & r[W];
    mag   = neg_c ? ((~r) + {{W{1'b0}}, 1'b1}) : r;
  end

  // one double-dabble step: add 3 to every digit >= 5, then shift left
  always_comb begin
    adj = sr;
    for (int i = 0; i < D; i++) begin
      if (sr[W+1+4*i +: 4] >= 4'd5)
        adj[W+1+4*i +: 4] = sr[W+1+4*i +: 4] + 4'd3;
    end
    nxt = {adj[SW-2:0], 1'b0};
  end

  // control FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
      r_q   <= '0;
      neg_q <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      neg   <= 1'b0;
      bcd   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            r_q   <= r;
            neg_q <= neg_c;
            sr    <= {{(4*D){1'b0}}, mag};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          sr  <= nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W - 1))
            state <= DONE;
        end
        DONE: begin
          cnt   <= cnt + 1'b1;
          sum   <= r_q;
          neg   <= neg_q;
          bcd   <= nxt[SW-1:W+1];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_addsub_seq.sv
// Scoreboard bench for bcd_addsub_seq: the drivers push expected results
// together with the cycle in which done must appear, and the monitors pop and
// compare on every done pulse.
module tb_bcd_addsub_seq;

  typedef struct {
    logic [12:0] sum;
    logic        neg;
    logic [15:0] bcd;
    int          t;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // main instance, W=8 D=3
  logic        start8 = 0, cin8 = 0, sub8 = 0;
  logic [7:0]  a8 = 0, b8 = 0;
  logic        busy8, done8, neg8;
  logic [8:0]  sum8;
  logic [11:0] bcd8;
  // sweep instances
  logic        start4 = 0, cin4 = 0, sub4 = 0;
  logic [3:0]  a4 = 0, b4 = 0;
  logic        busy4, done4, neg4;
  logic [4:0]  sum4;
  logic [7:0]  bcd4;
  logic        start12 = 0, cin12 = 0, sub12 = 0;
  logic [11:0] a12 = 0, b12 = 0;
  logic        busy12, done12, neg12;
  logic [12:0] sum12;
  logic [15:0] bcd12;

  exp_t q8[$];
  exp_t q4[$];
  exp_t q12[$];

  bcd_addsub_seq #(.W(8), .D(3)) dut (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .busy(busy8), .done(done8), .sum(sum8), .neg(neg8), .bcd(bcd8));

  bcd_addsub_seq #(.W(4), .D(2)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .busy(busy4), .done(done4), .sum(sum4), .neg(neg4), .bcd(bcd4));

  bcd_addsub_seq #(.W(12), .D(4)) dut12 (
    .clk(clk), .reset(reset), .start(start12), .a(a12), .b(b12), .cin(cin12), .sub(sub12),
    .busy(busy12), .done(done12), .sum(sum12), .neg(neg12), .bcd(bcd12));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // decimal reference built with division, independent of the shift-add-3 engine
  function automatic exp_t ref_model(input int w, input int aa, input int bb,
                                     input int c, input int s, input int t);
    exp_t e;
    int rr, m;
    rr = s ? (aa - bb - c) : (aa + bb + c);
    e.sum = 13'(rr & ((1 << (w + 1)) - 1));
    e.neg = (s != 0) && (rr < 0);
    m = e.neg ? -rr : rr;
    e.bcd = '0;
    for (int i = 0; i < 4; i++) begin
      e.bcd[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    e.t = t;
    return e;
  endfunction

  // monitors: one per instance, comparing on each done pulse
  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) chk("w8_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q8.pop_front();
        chk("w8_sum", 32'(sum8), 32'(e.sum));
        chk("w8_neg", 32'(neg8), 32'(e.neg));
        chk("w8_bcd", 32'(bcd8), 32'(e.bcd));
        chk("w8_done_cycle", cyc, e.t);
        chk("w8_busy_with_done", 32'(busy8), 0);
      end
    end
  end

  always @(negedge clk) begin
    if (done4) begin
      if (q4.size() == 0) chk("w4_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q4.pop_front();
        chk("w4_sum", 32'(sum4), 32'(e.sum));
        chk("w4_neg", 32'(neg4), 32'(e.neg));
        chk("w4_bcd", 32'(bcd4), 32'(e.bcd));
        chk("w4_done_cycle", cyc, e.t);
      end
    end
  end

  always @(negedge clk) begin
    if (done12) begin
      if (q12.size() == 0) chk("w12_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q12.pop_front();
        chk("w12_sum", 32'(sum12), 32'(e.sum));
        chk("w12_neg", 32'(neg12), 32'(e.neg));
        chk("w12_bcd", 32'(bcd12), 32'(e.bcd));
        chk("w12_done_cycle", cyc, e.t);
      end
    end
  end

  // single W=8 operation with hand-computed expected result
  task automatic op8(input int aa, input int bb, input int c, input int s,
                     input logic [8:0] es, input logic en, input logic [11:0] eb);
    exp_t e;
    @(negedge clk);
    a8 = 8'(aa); b8 = 8'(bb); cin8 = c[0]; sub8 = s[0]; start8 = 1'b1;
    e.sum = 13'(es); e.neg = en; e.bcd = 16'(eb); e.t = cyc + 10;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~a8; b8 = ~b8; cin8 = ~cin8; sub8 = ~sub8;   // must not disturb the run
    chk("w8_busy_after_start", 32'(busy8), 1);
    repeat (11) @(negedge clk);
  endtask

  initial begin
    int n, k;
    #1;
    chk("reset_busy", 32'(busy8), 0);
    chk("reset_done", 32'(done8), 0);
    chk("reset_sum", 32'(sum8), 0);
    chk("reset_neg", 32'(neg8), 0);
    chk("reset_bcd", 32'(bcd8), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    op8(255, 255, 1, 0, 9'h1FF, 1'b0, 12'h511);
    op8(5, 9, 0, 1, 9'h1FC, 1'b1, 12'h004);
    op8(9, 9, 1, 1, 9'h1FF, 1'b1, 12'h001);
    op8(0, 0, 0, 0, 9'h000, 1'b0, 12'h000);
    op8(123, 77, 0, 0, 9'h0C8, 1'b0, 12'h200);
    op8(0, 255, 1, 1, 9'h100, 1'b1, 12'h256);

    // start re-pulsed with a=99 at edges +3 and +9 must be ignored
    begin
      exp_t e;
      @(negedge clk);
      a8 = 8'd10; b8 = 8'd20; cin8 = 0; sub8 = 0; start8 = 1'b1;
      n = cyc; k = n + 1;
      e.sum = 13'h01E; e.neg = 0; e.bcd = 16'h030; e.t = n + 10;
      q8.push_back(e);
      @(negedge clk);
      start8 = 1'b0; a8 = 8'd99;
      while (cyc < k + 12) begin
        @(negedge clk);
        start8 = (cyc == k + 2) || (cyc == k + 8);
      end
      start8 = 1'b0;
      repeat (12) @(negedge clk);
    end

    // reset asserted after edge +4 of a conversion
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd100; cin8 = 0; sub8 = 0; start8 = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start8 = 1'b0;
    while (cyc < k + 4) @(negedge clk);
    chk("busy_before_reset", 32'(busy8), 1);
    reset = 1'b1;
    #1;
    chk("midreset_busy", 32'(busy8), 0);
    chk("midreset_done", 32'(done8), 0);
    chk("midreset_sum", 32'(sum8), 0);
    chk("midreset_neg", 32'(neg8), 0);
    chk("midreset_bcd", 32'(bcd8), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (14) @(negedge clk);
    op8(1, 2, 0, 0, 9'h003, 1'b0, 12'h003);

    // start held high: an operation every W+2 = 10 cycles
    @(negedge clk);
    a8 = 8'd50; b8 = 8'd25; cin8 = 0; sub8 = 0; start8 = 1'b1;
    n = cyc;
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.sum = 13'h04B; e.neg = 0; e.bcd = 16'h075; e.t = n + 10 + 10 * i;
      q8.push_back(e);
    end
    while (cyc < n + 31) @(negedge clk);
    start8 = 1'b0;
    repeat (14) @(negedge clk);

    // random sweep W=4 D=2, back-to-back
    for (int i = 0; i < 1000; i++) begin
      int aa, bb, c, s;
      @(negedge clk);
      aa = $urandom_range(0, 15); bb = $urandom_range(0, 15);
      c = $urandom_range(0, 1); s = $urandom_range(0, 1);
      if (i == 0) begin aa = 15; bb = 15; c = 1; s = 0; end
      if (i == 1) begin aa = 0; bb = 15; c = 1; s = 1; end
      a4 = 4'(aa); b4 = 4'(bb); cin4 = c[0]; sub4 = s[0]; start4 = 1'b1;
      q4.push_back(ref_model(4, aa, bb, c, s, cyc + 6));
      @(negedge clk);
      start4 = 1'b0;
      repeat (4) @(negedge clk);
    end

    // random sweep W=12 D=4, back-to-back
    for (int i = 0; i < 1000; i++) begin
      int aa, bb, c, s;
      @(negedge clk);
      aa = $urandom_range(0, 4095); bb = $urandom_range(0, 4095);
      c = $urandom_range(0, 1); s = $urandom_range(0, 1);
      if (i == 0) begin aa = 4095; bb = 4095; c = 1; s = 0; end
      if (i == 1) begin aa = 0; bb = 4095; c = 1; s = 1; end
      a12 = 12'(aa); b12 = 12'(bb); cin12 = c[0]; sub12 = s[0]; start12 = 1'b1;
      q12.push_back(ref_model(12, aa, bb, c, s, cyc + 14));
      @(negedge clk);
      start12 = 1'b0;
      repeat (12) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    chk("w8_pending", q8.size(), 0);
    chk("w4_pending", q4.size(), 0);
    chk("w12_pending", q12.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
